// File: rtl/csr_file.sv
// Machine-mode CSR register file for the rv32ima execute stage: CSR read/modify/write,
// trap entry and mret bookkeeping, and the 64-bit cycle/instret/hpm counters.
module csr_file #(
  parameter int          XLEN        = 32,
  parameter int          NUM_HPM     = 4,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 csr_valid,
  input  logic [11:0]                          csr_index,
  input  logic [2:0]                           csr_op,
  input  logic                                 csr_ren,
  input  logic                                 csr_wen,
  input  logic [XLEN-1:0]                      csr_rs1_val,
  input  logic [4:0]                           csr_uimm,
  output logic [XLEN-1:0]                      csr_rdata,
  output logic                                 csr_illegal,
  input  logic                                 instret_inc,
  input  logic [(NUM_HPM>0 ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic                                 trap_valid,
  input  logic [XLEN-1:0]                      trap_cause,
  input  logic [XLEN-1:0]                      trap_pc,
  output logic [XLEN-1:0]                      trap_vector,
  input  logic                                 mret_valid,
  output logic [XLEN-1:0]                      mret_pc,
  output logic                                 irq_enable
);

  localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic [63:0] hpm_q [HPM_N];
  logic [63:0] hpm_d [HPM_N];

  logic [31:0] mstatus_rd;
  logic [31:0] old_val;
  logic [31:0] src_val;
  logic [31:0] new_val;
  logic [31:0] tvec_base;
  logic        hit;
  logic        csr_wr;

  // MPP is hardwired to machine mode; only MIE and MPIE are stored.
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    hit     = 1'b1;
    old_val = 32'h0;
    case (csr_index)
      12'h300:          old_val = mstatus_rd;
      12'h305:          old_val = mtvec_q;
      12'h340:          old_val = mscratch_q;
      12'h341:          old_val = mepc_q;
      12'h342:          old_val = mcause_q;
      12'hB00, 12'hC00: old_val = mcycle_q[31:0];
      12'hB80, 12'hC80: old_val = mcycle_q[63:32];
      12'hB02, 12'hC02: old_val = minstret_q[31:0];
      12'hB82, 12'hC82: old_val = minstret_q[63:32];
      12'hF14:          old_val = 32'h0;
      default: begin
        hit = 1'b0;
        for (int k = 0; k < NUM_HPM; k++) begin
          if (csr_index == 12'(12'hB03 + k)) begin
            hit     = 1'b1;
            old_val = hpm_q[k][31:0];
          end
          if (csr_index == 12'(12'hB83 + k)) begin
            hit     = 1'b1;
            old_val = hpm_q[k][63:32];
          end
        end
      end
    endcase
  end

  assign csr_illegal = csr_valid &
                       (~hit | (csr_wen & (csr_index[11:10] == 2'b11)) | (csr_op[1:0] == 2'b00));

  assign csr_rdata = (csr_valid & csr_ren & ~csr_illegal) ? old_val : 32'h0;

  assign src_val = csr_op[2] ? {27'b0, csr_uimm} : csr_rs1_val;

  always_comb begin
    case (csr_op[1:0])
      2'b10:   new_val = old_val | src_val;
      2'b11:   new_val = old_val & ~src_val;
      default: new_val = src_val;
    endcase
  end

  // A trap in the same cycle squashes the instruction, so its write never lands.
  assign csr_wr = csr_valid & csr_wen & ~csr_illegal & ~trap_valid;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instret_inc};
    for (int k = 0; k < HPM_N; k++) begin
      hpm_d[k] = hpm_q[k];
    end
    for (int k = 0; k < NUM_HPM; k++) begin
      hpm_d[k] = hpm_q[k] + {63'b0, hpm_event[k]};
    end

    // Counter writes replace the increment; the untouched half keeps its old value.
    if (csr_wr) begin
      case (csr_index)
        12'h300: begin
          mie_d  = new_val[3];
          mpie_d = new_val[7];
        end
        12'h305: mtvec_d    = new_val[1] ? (new_val & ~32'h3) : new_val;
        12'h340: mscratch_d = new_val;
        12'h341: mepc_d     = new_val & ~32'h3;
        12'h342: mcause_d   = new_val;
        12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
        12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], new_val};
        12'hB82: minstret_d = {new_val, minstret_q[31:0]};
        default: begin
          for (int k = 0; k < NUM_HPM; k++) begin
            if (csr_index == 12'(12'hB03 + k)) hpm_d[k] = {hpm_q[k][63:32], new_val};
            if (csr_index == 12'(12'hB83 + k)) hpm_d[k] = {new_val, hpm_q[k][31:0]};
          end
        end
      endcase
    end

    if (mret_valid && !trap_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (trap_valid) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
      for (int k = 0; k < HPM_N; k++) begin
        hpm_q[k] <= 64'h0;
      end
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      for (int k = 0; k < HPM_N; k++) begin
        hpm_q[k] <= hpm_d[k];
      end
    end
  end

  // Vectored mode only redirects interrupts; exceptions always use the base.
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    trap_vector = tvec_base;
    if (mtvec_q[1:0] == 2'b01 && trap_cause[31]) begin
      trap_vector = tvec_base + {trap_cause[29:0], 2'b00};
    end
  end

  assign mret_pc    = mepc_q;
  assign irq_enable = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed walk through the main CSR scenarios, then random traffic,
// all compared every cycle against an architectural model of the machine CSRs.
module tb_csr_file;
  localparam int NUM_HPM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [11:0] csr_index;
  logic [2:0]  csr_op;
  logic        csr_ren;
  logic        csr_wen;
  logic [31:0] csr_rs1_val;
  logic [4:0]  csr_uimm;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instret_inc;
  logic [3:0]  hpm_event;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_vector;
  logic        mret_valid;
  logic [31:0] mret_pc;
  logic        irq_enable;

  always #5 clk = ~clk;

  csr_file #(.XLEN(32), .NUM_HPM(NUM_HPM), .RESET_MTVEC(32'h0)) dut (
    .clk(clk), .rst(rst), .csr_valid(csr_valid), .csr_index(csr_index), .csr_op(csr_op),
    .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_rs1_val(csr_rs1_val), .csr_uimm(csr_uimm),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .instret_inc(instret_inc),
    .hpm_event(hpm_event), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_vector(trap_vector), .mret_valid(mret_valid),
    .mret_pc(mret_pc), .irq_enable(irq_enable)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Architectural state; counters are kept by number (0 cycle, 2 instret, 3.. hpm).
  bit          model_ok = 1'b0;
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_ctr [32];

  logic [31:0] s_rdata, s_tv, s_mretpc;
  logic        s_ill, s_irq;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit ctr_ok(int n);
    return n == 0 || n == 2 || (n >= 3 && n < 3 + NUM_HPM);
  endfunction

  function automatic bit m_read(logic [11:0] idx, output logic [31:0] v);
    int n;
    n = int'(idx[4:0]);
    v = 32'h0;
    if (idx == 12'h300) begin
      v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      return 1'b1;
    end
    if (idx == 12'h305) begin v = m_mtvec;    return 1'b1; end
    if (idx == 12'h340) begin v = m_mscratch; return 1'b1; end
    if (idx == 12'h341) begin v = m_mepc;     return 1'b1; end
    if (idx == 12'h342) begin v = m_mcause;   return 1'b1; end
    if (idx == 12'hF14) return 1'b1;
    if ((idx[11:8] == 4'hB && idx[6:5] == 2'b00 && ctr_ok(n)) ||
        (idx[11:8] == 4'hC && idx[6:5] == 2'b00 && (n == 0 || n == 2))) begin
      v = idx[7] ? m_ctr[n][63:32] : m_ctr[n][31:0];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
    for (int n = 0; n < 32; n++) m_ctr[n] = 64'h0;
    model_ok = 1'b1;
  endtask

  task automatic model_update(logic [31:0] oldv, bit ill);
    logic [63:0] nctr [32];
    logic [31:0] src, nv;
    bit          wr, inc, n_mie, n_mpie;
    int          n;
    wr  = csr_valid && csr_wen && !ill && !trap_valid;
    src = csr_op[2] ? {27'b0, csr_uimm} : csr_rs1_val;
    case (csr_op[1:0])
      2'b01:   nv = src;
      2'b10:   nv = oldv | src;
      default: nv = oldv & ~src;
    endcase
    for (int k = 0; k < 32; k++) begin
      inc = 0;
      if (k == 0) inc = 1;
      else if (k == 2) inc = instret_inc;
      else if (k >= 3 && k < 3 + NUM_HPM) inc = hpm_event[k-3];
      nctr[k] = m_ctr[k] + 64'(inc);
    end
    n_mie = m_mie; n_mpie = m_mpie;
    if (wr && csr_index[11:8] == 4'hB) begin
      n = int'(csr_index[4:0]);
      nctr[n] = csr_index[7] ? {nv, m_ctr[n][31:0]} : {m_ctr[n][63:32], nv};
    end
    if (wr && csr_index == 12'h300) begin n_mie = nv[3]; n_mpie = nv[7]; end
    if (wr && csr_index == 12'h305) m_mtvec = (nv[1:0] >= 2'd2) ? (nv & ~32'h3) : nv;
    if (wr && csr_index == 12'h340) m_mscratch = nv;
    if (wr && csr_index == 12'h341) m_mepc = nv & ~32'h3;
    if (wr && csr_index == 12'h342) m_mcause = nv;
    if (mret_valid && !trap_valid) begin n_mie = m_mpie; n_mpie = 1; end
    if (trap_valid) begin
      m_mepc   = trap_pc & ~32'h3;
      m_mcause = trap_cause;
      n_mpie   = m_mie;
      n_mie    = 0;
    end
    m_mie = n_mie; m_mpie = n_mpie;
    m_ctr = nctr;
  endtask

  // One clock: sample at negedge, compare with the model, advance model, then pass posedge.
  task automatic step();
    logic [31:0] oldv, e_rd, e_tv;
    bit          found, e_ill;
    @(negedge clk);
    s_rdata = csr_rdata; s_ill = csr_illegal; s_tv = trap_vector;
    s_mretpc = mret_pc; s_irq = irq_enable;
    if (model_ok) begin
      found = m_read(csr_index, oldv);
      e_ill = csr_valid && (!found || (csr_wen && csr_index[11:10] == 2'b11) ||
                            csr_op == 3'b000 || csr_op == 3'b100);
      e_rd  = (csr_valid && csr_ren && !e_ill) ? oldv : 32'h0;
      e_tv  = m_mtvec & ~32'h3;
      if (m_mtvec[1:0] == 2'b01 && trap_cause[31])
        e_tv = e_tv + 32'd4 * (trap_cause & 32'h7FFF_FFFF);
      check("rdata", s_rdata, e_rd);
      check("illegal", 32'(s_ill), 32'(e_ill));
      check("trap_vector", s_tv, e_tv);
      check("mret_pc", s_mretpc, m_mepc);
      check("irq_enable", 32'(s_irq), 32'(m_mie));
      if (rst) model_reset();
      else model_update(oldv, e_ill);
    end else if (rst) begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    csr_valid = 0; csr_index = 12'h0; csr_op = 3'b0; csr_ren = 0; csr_wen = 0;
    csr_rs1_val = 32'h0; csr_uimm = 5'h0; instret_inc = 0; hpm_event = 4'h0;
    trap_valid = 0; trap_cause = 32'h0; trap_pc = 32'h0; mret_valid = 0;
  endtask

  task automatic csr(logic [11:0] idx, logic [2:0] op, bit ren, bit wen,
                     logic [31:0] rs1, logic [4:0] uimm);
    clr();
    csr_valid = 1; csr_index = idx; csr_op = op; csr_ren = ren; csr_wen = wen;
    csr_rs1_val = rs1; csr_uimm = uimm;
  endtask

  localparam int NIDX = 24;
  logic [11:0] idx_tab [NIDX] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00,
                                 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                                 12'hB06, 12'hB86, 12'hB07, 12'hB01, 12'hC00, 12'hC02,
                                 12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'hC03, 12'hB83};

  initial begin
    clr();
    rst = 1;
    step(); step();
    rst = 0;
    step();
    check("lit_rst_irq", 32'(s_irq), 32'h0);
    check("lit_rst_mretpc", s_mretpc, 32'h0);
    check("lit_rst_rdata", s_rdata, 32'h0);

    csr(12'h340, 3'b001, 1, 1, 32'hDEADBEEF, 0); step();
    check("lit_mscratch_rw_old", s_rdata, 32'h0);
    csr(12'h340, 3'b010, 1, 0, 0, 0); step();
    check("lit_mscratch_rd", s_rdata, 32'hDEADBEEF);
    csr(12'h340, 3'b110, 1, 1, 0, 5'h10); step();
    check("lit_mscratch_rsi_old", s_rdata, 32'hDEADBEEF);
    csr(12'h340, 3'b011, 1, 1, 32'hFF, 0); step();
    check("lit_mscratch_rc_old", s_rdata, 32'hDEADBEFF);
    csr(12'h340, 3'b010, 1, 0, 0, 0); step();
    check("lit_mscratch_rc_new", s_rdata, 32'hDEADBE00);

    csr(12'hC00, 3'b001, 1, 1, 32'h55, 0); step();
    check("lit_cycle_wr_illegal", 32'(s_ill), 32'h1);
    check("lit_cycle_wr_rdata", s_rdata, 32'h0);
    csr(12'h7C0, 3'b001, 1, 1, 32'h55, 0); step();
    check("lit_unimpl_illegal", 32'(s_ill), 32'h1);
    csr(12'hC00, 3'b010, 1, 0, 0, 0); step();
    check("lit_cycle_rd_legal", 32'(s_ill), 32'h0);

    csr(12'hB00, 3'b001, 0, 1, 32'hFFFF_FFFF, 0); step();
    csr(12'hB80, 3'b001, 0, 1, 32'h0, 0); step();
    clr(); step();
    csr(12'hB00, 3'b010, 1, 0, 0, 0); step();
    check("lit_mcycle_wrap_lo", s_rdata, 32'h0);
    csr(12'hB80, 3'b010, 1, 0, 0, 0); step();
    check("lit_mcycle_wrap_hi", s_rdata, 32'h1);

    clr(); instret_inc = 1;
    repeat (5) step();
    csr(12'hB02, 3'b010, 1, 0, 0, 0); step();
    check("lit_minstret5", s_rdata, 32'd5);
    repeat (3) begin
      clr(); hpm_event = 4'b0010; step();
      clr(); step();
    end
    csr(12'hB04, 3'b010, 1, 0, 0, 0); step();
    check("lit_hpm4_3", s_rdata, 32'd3);

    csr(12'h300, 3'b110, 0, 1, 0, 5'd8); step();
    csr(12'h305, 3'b001, 0, 1, 32'h101, 0); step();
    check("lit_mie_set", 32'(s_irq), 32'h1);
    clr(); trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1002; step();
    check("lit_trap_vector", s_tv, 32'h11C);
    csr(12'h341, 3'b010, 1, 0, 0, 0); step();
    check("lit_mepc", s_rdata, 32'h1000);
    check("lit_trap_irq", 32'(s_irq), 32'h0);
    check("lit_trap_mretpc", s_mretpc, 32'h1000);
    csr(12'h342, 3'b010, 1, 0, 0, 0); step();
    check("lit_mcause", s_rdata, 32'h8000_0007);
    csr(12'h300, 3'b010, 1, 0, 0, 0); step();
    check("lit_mstatus_trap", s_rdata, 32'h1880);

    clr(); mret_valid = 1; step();
    csr(12'h300, 3'b010, 1, 0, 0, 0); step();
    check("lit_mstatus_mret", s_rdata, 32'h1888);
    check("lit_mret_irq", 32'(s_irq), 32'h1);

    csr(12'h300, 3'b001, 1, 1, 32'h0, 0);
    trap_valid = 1; trap_cause = 32'h5; trap_pc = 32'h2000; mret_valid = 1; step();
    csr(12'h300, 3'b010, 1, 0, 0, 0); step();
    check("lit_prio_mstatus", s_rdata, 32'h1880);
    csr(12'h341, 3'b010, 1, 0, 0, 0); step();
    check("lit_prio_mepc", s_rdata, 32'h2000);

    csr(12'h305, 3'b001, 0, 1, 32'h203, 0); step();
    csr(12'h305, 3'b010, 1, 0, 0, 0); step();
    check("lit_mtvec_warl", s_rdata, 32'h200);

    csr(12'h340, 3'b001, 1, 1, 32'h1234_5678, 0); rst = 1; step();
    rst = 0;
    csr(12'h340, 3'b010, 1, 0, 0, 0); step();
    check("lit_rst_mscratch", s_rdata, 32'h0);
    csr(12'h305, 3'b010, 1, 0, 0, 0); step();
    check("lit_rst_mtvec", s_rdata, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      clr();
      csr_valid   = ($urandom_range(0, 9) < 8);
      csr_index   = idx_tab[$urandom_range(0, NIDX-1)];
      csr_op      = 3'($urandom_range(0, 7));
      csr_ren     = 1'($urandom_range(0, 1));
      csr_wen     = 1'($urandom_range(0, 1));
      csr_rs1_val = $urandom();
      csr_uimm    = 5'($urandom_range(0, 31));
      instret_inc = 1'($urandom_range(0, 1));
      hpm_event   = 4'($urandom_range(0, 15));
      trap_valid  = ($urandom_range(0, 19) == 0);
      trap_cause  = {1'($urandom_range(0, 1)), 26'b0, 5'($urandom_range(0, 31))};
      trap_pc     = $urandom();
      mret_valid  = ($urandom_range(0, 19) == 0);
      if (csr_index == 12'h305 && $urandom_range(0, 1) == 1) csr_rs1_val[1:0] = 2'b01;
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
